// File: rtl/seq_pkg.sv
// Package for the 1-0-1 serial pattern detector.
// Holds the FSM state encoding and the fixed pattern constant shared by the
// detector, its pin-bundle interface and any scoreboard that probes the state.
package seq_pkg;

  // Each state names the longest prefix of the pattern matched so far.
  typedef enum logic [1:0] {
    IDLE = 2'b00,  // no useful prefix
    S1   = 2'b01,  // seen "1"
    S10  = 2'b10,  // seen "10"
    S101 = 2'b11   // full match
  } state_e;

  // Pattern bits, MSB is the first bit received.
  localparam logic [2:0] SEQ_PATTERN = 3'b101;

endpackage

// File: rtl/seq_intf.sv
// Pin bundle for seq101_detector.
// Ports:
//   clk          - rising-edge system clock (interface port)
//   rst_n        - asynchronous active-low reset
//   data_in      - serial data bit
//   seq_detected - one-cycle detection pulse
// The dut modport is seen from the detector, and the tb modport is its mirror.
// The clocking block samples and drives on the rising edge.
interface seq_intf (
  input logic clk
);

  logic rst_n;
  logic data_in;
  logic seq_detected;

  clocking cb @(posedge clk);
    input  seq_detected;
    output rst_n;
    output data_in;
  endclocking

  modport dut (
    input  clk,
    input  rst_n,
    input  data_in,
    output seq_detected
  );

  modport tb (
    input  clk,
    input  seq_detected,
    output rst_n,
    output data_in
  );

endinterface

// File: rtl/seq101_detector.sv
// Serial 1-0-1 pattern detector. This is a Moore FSM that detects
// overlapping occurrences.
// Ports:
//   clk          in  1  rising-edge system clock
//   rst_n        in  1  asynchronous active-low reset (deassertion is
//                       synchronised outside this block)
//   data_in      in  1  serial bit, sampled on rising clk
//   seq_detected out 1  high for the one cycle after the last pattern bit
module seq101_detector
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic seq_detected
);

  state_e state;
  state_e next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = data_in ? S1   : IDLE;
      S1:      next_state = data_in ? S1   : S10;
      S10:     next_state = data_in ? S101 : IDLE;
      // The trailing "1" of a match is reused as a new prefix.
      S101:    next_state = data_in ? S1   : S10;
      default: next_state = IDLE;
    endcase
  end

  // The output is decoded from the state register alone, so it is glitch-free
  // with respect to data_in.
  assign seq_detected = (state == S101);

`ifndef SYNTHESIS
  // A pulse must be backed by the last three sampled bits.
  a_pulse_has_pattern: assert property (
    @(posedge clk) disable iff (!rst_n)
    seq_detected |-> ($past(data_in, 3) == SEQ_PATTERN[2] &&
                      $past(data_in, 2) == SEQ_PATTERN[1] &&
                      $past(data_in, 1) == SEQ_PATTERN[0]));

  a_no_back_to_back: assert property (
    @(posedge clk) disable iff (!rst_n)
    seq_detected |=> !seq_detected);

  a_quiet_in_reset: assert property (
    @(posedge clk) !rst_n |-> !seq_detected);
`endif

endmodule

// File: tb/tb_seq101_detector.sv
// Self-checking bench for seq101_detector. The reference model keeps the raw
// bit history since the last reset. It derives the expected pulse and the
// expected state, which is the longest pattern prefix ending the history.
module tb_seq101_detector;

  logic clk = 1'b0;
  logic rst_n;
  logic data_in;
  logic seq_detected;

  int checks = 0;
  int failures = 0;

  // Reference model: the bits received since reset, newest in bit 0.
  logic [2:0] hist;
  int         nbits;

  seq101_detector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .seq_detected (seq_detected)
  );

  always #5 clk = ~clk;

  function automatic logic exp_pulse();
    return (nbits >= 3) && (hist == 3'b101);
  endfunction

  // Expected state code: 3 = full match, 2 = "10", 1 = "1", 0 = nothing.
  function automatic logic [1:0] exp_state();
    if (nbits >= 3 && hist == 3'b101) return 2'd3;
    if (nbits >= 2 && hist[1:0] == 2'b10) return 2'd2;
    if (nbits >= 1 && hist[0]) return 2'd1;
    return 2'd0;
  endfunction

  // Drives one bit on the falling edge and returns 1 ns after the next
  // rising edge, with the model updated.
  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in = b;
    @(posedge clk);
    #1;
    hist = {hist[1:0], b};
    if (nbits < 3) nbits++;
  endtask

  task automatic model_reset();
    hist  = 3'b000;
    nbits = 0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    data_in = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      #5;
      checks++;
      if (dut.state !== 2'd0 || seq_detected !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold t=%0t state=%0d det=%b expected state=0 det=0",
                 $time, dut.state, seq_detected);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_bits(input string name, input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (dut.state !== exp_state() || seq_detected !== exp_pulse()) begin
        failures++;
        $display("FAIL %s bit%0d state=%0d det=%b expected state=%0d det=%b",
                 name, n - 1 - i, dut.state, seq_detected, exp_state(), exp_pulse());
      end
    end
  endtask

  task automatic test_basic();
    run_bits("basic_101", 8'b101, 3);
    checks++;
    if (seq_detected !== 1'b1) begin
      failures++;
      $display("FAIL basic_pulse det=%b expected 1", seq_detected);
    end
  endtask

  task automatic test_overlap();
    run_bits("overlap_10", 8'b10, 2);
    run_bits("overlap_1", 8'b1, 1);
    checks++;
    if (seq_detected !== 1'b1 || dut.state !== 2'd3) begin
      failures++;
      $display("FAIL overlap_pulse det=%b state=%0d expected det=1 state=3",
               seq_detected, dut.state);
    end
  endtask

  task automatic test_ones_then_match();
    run_bits("ones_1101", 8'b1101, 4);
  endtask

  task automatic test_no_match();
    run_bits("nomatch_1001", 8'b1001, 4);
    checks++;
    if (seq_detected !== 1'b0 || dut.state !== 2'd1) begin
      failures++;
      $display("FAIL nomatch_end det=%b state=%0d expected det=0 state=1",
               seq_detected, dut.state);
    end
  endtask

  task automatic test_mid_reset();
    run_bits("midrst_10", 8'b10, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut.state !== 2'd0 || seq_detected !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async state=%0d det=%b expected state=0 det=0",
               dut.state, seq_detected);
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== 2'd0 || seq_detected !== 1'b0) begin
      failures++;
      $display("FAIL midrst_hold state=%0d det=%b expected state=0 det=0",
               dut.state, seq_detected);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // A lone "1" after reset must not complete the pre-reset "10".
    run_bits("midrst_101", 8'b101, 3);
  endtask

  task automatic test_random();
    int pulses = 0;
    int exp_pulses = 0;
    for (int i = 0; i < 400; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      send_bit(b);
      if (exp_pulse()) exp_pulses++;
      if (seq_detected === 1'b1) pulses++;
      checks++;
      if (dut.state !== exp_state() || seq_detected !== exp_pulse()) begin
        failures++;
        $display("FAIL random bit%0d in=%b state=%0d det=%b expected state=%0d det=%b",
                 i, b, dut.state, seq_detected, exp_state(), exp_pulse());
      end
    end
    checks++;
    if (pulses != exp_pulses) begin
      failures++;
      $display("FAIL random_count pulses=%0d expected %0d", pulses, exp_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_ones_then_match();
    test_no_match();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
